mem_region_router: RTL and testbench

MEM_REGION_ROUTER -- requirements
Module: mem_region_router

---
 rtl/mem_region_router_pkg.sv | 14 +
 rtl/mem_region_router_if.sv | 49 ++++
 rtl/mem_region_router.sv | 103 ++++++++++
 tb/tb_mem_region_router.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_region_router_pkg.sv
// mem_region_router_pkg: shared sizes, default region/timeout constants and FSM states
package mem_region_router_pkg;
    localparam int ADDR_SIZE        = 32;
    localparam int DATA_SIZE        = 32;
    localparam int INT_MEM_SIZE_DEF = 200;
    localparam int TIMEOUT_DEF      = 255;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_e;
endpackage

// File: rtl/mem_region_router_if.sv
// mem_region_router_if: requester, internal RAM and external controller signals of the router
interface mem_region_router_if
    import mem_region_router_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE,
    parameter int DATA_W = DATA_SIZE
);
    logic              clk_oe;
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_halt;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_rd_dn;
    logic              rsp_wr_dn;
    logic              rsp_err;
    logic              busy;
    logic              int_rd_q;
    logic              int_wr_q;
    logic [ADDR_W-1:0] int_addr;
    logic [DATA_W-1:0] int_wdata;
    logic [DATA_W-1:0] int_rdata;
    logic              int_rd_dn;
    logic              int_wr_dn;
    logic              ext_rd_q;
    logic              ext_wr_q;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rd_dn;
    logic              ext_wr_dn;
    modport slave (
        input  clk_oe, req_rd, req_wr, req_addr, req_wdata, req_halt,
        output rsp_rdata, rsp_rd_dn, rsp_wr_dn, rsp_err, busy,
        output int_rd_q, int_wr_q, int_addr, int_wdata,
        input  int_rdata, int_rd_dn, int_wr_dn,
        output ext_rd_q, ext_wr_q, ext_addr, ext_wdata,
        input  ext_rdata, ext_rd_dn, ext_wr_dn
    );
    modport master (
        output clk_oe, req_rd, req_wr, req_addr, req_wdata, req_halt,
        input  rsp_rdata, rsp_rd_dn, rsp_wr_dn, rsp_err, busy,
        input  int_rd_q, int_wr_q, int_addr, int_wdata,
        output int_rdata, int_rd_dn, int_wr_dn,
        input  ext_rd_q, ext_wr_q, ext_addr, ext_wdata,
        output ext_rdata, ext_rd_dn, ext_wr_dn
    );
endinterface

// File: rtl/mem_region_router.sv
// mem_region_router: routes one requester transaction to internal RAM or the external controller by address
module mem_region_router
    import mem_region_router_pkg::*;
#(
    parameter int ADDR_W       = ADDR_SIZE,
    parameter int DATA_W       = DATA_SIZE,
    parameter int INT_MEM_SIZE = INT_MEM_SIZE_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input logic                clk,
    input logic                rst,
    mem_region_router_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    state_e            state_q, state_d;
    logic              rd_q, rd_d;
    logic              ext_q, ext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              active, dn_hit;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            ext_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            ext_q   <= ext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    // only the selected target's done for the latched op may complete the transaction
    assign dn_hit = ext_q ? (rd_q ? bus.ext_rd_dn : bus.ext_wr_dn)
                          : (rd_q ? bus.int_rd_dn : bus.int_wr_dn);
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        ext_d   = ext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q != IDLE && bus.req_halt) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (bus.clk_oe) begin
            unique case (state_q)
                IDLE: if ((bus.req_rd || bus.req_wr) && !bus.req_halt) begin
                    state_d = ISSUE;
                    rd_d    = bus.req_rd;
                    ext_d   = bus.req_addr >= ADDR_W'(INT_MEM_SIZE);
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (dn_hit) begin
                        state_d = DONE;
                        rdata_d = rd_q ? (ext_q ? bus.ext_rdata : bus.int_rdata) : rdata_q;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
                DONE: state_d = RELEASE;
                RELEASE: state_d = (!bus.req_rd && !bus.req_wr) ? IDLE : RELEASE;
                default: state_d = IDLE;
            endcase
        end
    end
    assign active        = state_q == ISSUE || state_q == WAIT;
    assign bus.int_rd_q  = active && !ext_q && rd_q;
    assign bus.int_wr_q  = active && !ext_q && !rd_q;
    assign bus.ext_rd_q  = active && ext_q && rd_q;
    assign bus.ext_wr_q  = active && ext_q && !rd_q;
    assign bus.int_addr  = ext_q ? '0 : addr_q;
    assign bus.int_wdata = ext_q ? '0 : wdata_q;
    assign bus.ext_addr  = ext_q ? addr_q - ADDR_W'(INT_MEM_SIZE) : '0;
    assign bus.ext_wdata = ext_q ? wdata_q : '0;
    assign bus.rsp_rd_dn = state_q == DONE && rd_q;
    assign bus.rsp_wr_dn = state_q == DONE && !rd_q;
    assign bus.rsp_err   = state_q == DONE && err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_region_router.sv
// tb_mem_region_router: directed scenarios for routing, timeout, halt/reset abort and clk_oe gating
module tb_mem_region_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic auto_int = 1'b0, auto_ext = 1'b0, stray_int = 1'b0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    mem_region_router_if #(.ADDR_W(32), .DATA_W(32)) bus();
    mem_region_router #(.ADDR_W(32), .DATA_W(32), .INT_MEM_SIZE(200), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    // memory models answer one cycle after seeing their strobe
    always @(posedge clk) begin
        bus.int_rd_dn <= (auto_int && bus.int_rd_q) || stray_int;
        bus.int_wr_dn <= auto_int && bus.int_wr_q;
        bus.ext_rd_dn <= auto_ext && bus.ext_rd_q;
        bus.ext_wr_dn <= auto_ext && bus.ext_wr_q;
    end
    task automatic start(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_rd    = rd;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask
    task automatic wait_done(input int first, input int limit, output int lat);
        lat = 0;
        for (int i = first; i <= limit; i++) begin
            @(negedge clk);
            if (bus.rsp_rd_dn || bus.rsp_wr_dn) begin
                lat = i;
                break;
            end
        end
    endtask
    task automatic release_req();
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.int_rd_q, bus.int_wr_q, bus.ext_rd_q, bus.ext_wr_q} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.busy, bus.int_rd_q, bus.int_wr_q, bus.ext_rd_q, bus.ext_wr_q});
        end
        checks++;
        if ({bus.int_addr, bus.ext_addr, bus.int_wdata, bus.ext_wdata, bus.rsp_rdata} !== 160'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus.int_addr, bus.ext_addr, bus.int_wdata, bus.ext_wdata, bus.rsp_rdata});
        end
        checks++;
        if ({bus.rsp_rd_dn, bus.rsp_wr_dn, bus.rsp_err} !== 3'b0) begin
            failures++;
            $display("FAIL reset_rsp got=%b exp=000", {bus.rsp_rd_dn, bus.rsp_wr_dn, bus.rsp_err});
        end
        rst = 1'b0;
    endtask
    task automatic test_int_read();
        int lat;
        auto_int = 1'b1;
        bus.int_rdata = 32'h1234;
        start(1'b1, 1'b0, 32'd10, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.int_rd_q, bus.int_wr_q, bus.ext_rd_q, bus.ext_wr_q} !== 4'b1000) begin
            failures++;
            $display("FAIL int_read_strobes got=%b exp=1000", {bus.int_rd_q, bus.int_wr_q, bus.ext_rd_q, bus.ext_wr_q});
        end
        checks++;
        if (bus.int_addr !== 32'd10 || bus.ext_addr !== 32'd0) begin
            failures++;
            $display("FAIL int_read_addr got=%0d/%0d exp=10/0", bus.int_addr, bus.ext_addr);
        end
        wait_done(2, 10, lat);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL int_read_latency got=%0d exp=3", lat);
        end
        checks++;
        if ({bus.rsp_rd_dn, bus.rsp_wr_dn, bus.rsp_err} !== 3'b100 || bus.rsp_rdata !== 32'h1234) begin
            failures++;
            $display("FAIL int_read_rsp got=%b/%h exp=100/00001234", {bus.rsp_rd_dn, bus.rsp_wr_dn, bus.rsp_err}, bus.rsp_rdata);
        end
        release_req();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL int_read_idle busy got=%b exp=0", bus.busy);
        end
        auto_int = 1'b0;
    endtask
    task automatic test_ext_write();
        int pulses = 0, qs = 0;
        auto_ext = 1'b1;
        start(1'b0, 1'b1, 32'd205, 32'hBEEF);
        @(negedge clk);
        checks++;
        if ({bus.ext_wr_q, bus.ext_rd_q, bus.int_wr_q, bus.int_rd_q} !== 4'b1000) begin
            failures++;
            $display("FAIL ext_write_strobes got=%b exp=1000", {bus.ext_wr_q, bus.ext_rd_q, bus.int_wr_q, bus.int_rd_q});
        end
        checks++;
        if (bus.ext_addr !== 32'd5 || bus.ext_wdata !== 32'hBEEF || bus.int_addr !== 32'd0 || bus.int_wdata !== 32'd0) begin
            failures++;
            $display("FAIL ext_write_bus got=%0d/%h int=%0d/%h exp=5/0000beef int=0/0", bus.ext_addr, bus.ext_wdata, bus.int_addr, bus.int_wdata);
        end
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            pulses += int'(bus.rsp_wr_dn);
            qs += int'(bus.ext_wr_q);
        end
        checks++;
        if (pulses !== 1 || qs !== 1) begin
            failures++;
            $display("FAIL ext_write_no_reissue pulses=%0d q_cycles=%0d exp=1/1", pulses, qs);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ext_write_release busy got=%b exp=1", bus.busy);
        end
        release_req();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ext_write_idle busy got=%b exp=0", bus.busy);
        end
    endtask
    task automatic test_boundary();
        int lat;
        auto_int = 1'b1;
        auto_ext = 1'b1;
        bus.int_rdata = 32'hAAAA;
        bus.ext_rdata = 32'h5678;
        start(1'b1, 1'b0, 32'd199, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.ext_rd_q, bus.int_rd_q} !== 2'b01 || bus.int_addr !== 32'd199) begin
            failures++;
            $display("FAIL boundary_199 got=%b addr=%0d exp=01 addr=199", {bus.ext_rd_q, bus.int_rd_q}, bus.int_addr);
        end
        wait_done(2, 10, lat);
        checks++;
        if (bus.rsp_rdata !== 32'hAAAA) begin
            failures++;
            $display("FAIL boundary_199_data got=%h exp=0000aaaa", bus.rsp_rdata);
        end
        release_req();
        start(1'b1, 1'b0, 32'd200, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.ext_rd_q, bus.int_rd_q} !== 2'b10 || bus.ext_addr !== 32'd0 || bus.int_addr !== 32'd0) begin
            failures++;
            $display("FAIL boundary_200 got=%b ext=%0d int=%0d exp=10 ext=0 int=0", {bus.ext_rd_q, bus.int_rd_q}, bus.ext_addr, bus.int_addr);
        end
        wait_done(2, 10, lat);
        checks++;
        if (lat !== 3 || bus.rsp_rdata !== 32'h5678) begin
            failures++;
            $display("FAIL boundary_200_data lat=%0d data=%h exp=3/00005678", lat, bus.rsp_rdata);
        end
        release_req();
        auto_int = 1'b0;
        auto_ext = 1'b0;
    endtask
    task automatic test_timeout();
        int lat = 0, qcnt = 0;
        start(1'b1, 1'b0, 32'd300, 32'h0);
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            qcnt += int'(bus.ext_rd_q);
            if (bus.rsp_rd_dn || bus.rsp_wr_dn) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 257 || qcnt !== 256) begin
            failures++;
            $display("FAIL timeout_len lat=%0d q_cycles=%0d exp=257/256", lat, qcnt);
        end
        checks++;
        if ({bus.rsp_rd_dn, bus.rsp_err, bus.ext_rd_q} !== 3'b110) begin
            failures++;
            $display("FAIL timeout_rsp got=%b exp=110", {bus.rsp_rd_dn, bus.rsp_err, bus.ext_rd_q});
        end
        checks++;
        if (bus.rsp_rdata !== 32'h5678) begin
            failures++;
            $display("FAIL timeout_rdata_hold got=%h exp=00005678", bus.rsp_rdata);
        end
        release_req();
    endtask
    task automatic test_stray();
        int pulses = 0, lat;
        bus.ext_rdata = 32'h9ABC;
        start(1'b1, 1'b0, 32'd250, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.ext_addr !== 32'd50) begin
            failures++;
            $display("FAIL stray_ext_addr got=%0d exp=50", bus.ext_addr);
        end
        stray_int = 1'b1;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(bus.rsp_rd_dn || bus.rsp_wr_dn || bus.rsp_err);
        end
        checks++;
        if (pulses !== 0 || bus.ext_rd_q !== 1'b1) begin
            failures++;
            $display("FAIL stray_ignored pulses=%0d ext_rd_q=%b exp=0/1", pulses, bus.ext_rd_q);
        end
        stray_int = 1'b0;
        auto_ext = 1'b1;
        wait_done(1, 10, lat);
        checks++;
        if (lat !== 2 || bus.rsp_rdata !== 32'h9ABC) begin
            failures++;
            $display("FAIL stray_complete lat=%0d data=%h exp=2/00009abc", lat, bus.rsp_rdata);
        end
        release_req();
        auto_ext = 1'b0;
    endtask
    task automatic test_halt();
        int pulses = 0;
        start(1'b1, 1'b0, 32'd10, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.int_rd_q !== 1'b1) begin
            failures++;
            $display("FAIL halt_pre int_rd_q got=%b exp=1", bus.int_rd_q);
        end
        bus.req_halt = 1'b1;
        bus.req_rd = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.int_rd_q, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL halt_wait got=%b exp=00", {bus.int_rd_q, bus.busy});
        end
        bus.req_halt = 1'b0;
        start(1'b0, 1'b1, 32'd20, 32'h77);
        repeat (3) @(negedge clk);
        bus.clk_oe = 1'b0;
        bus.req_halt = 1'b1;
        bus.req_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.int_wr_q, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL halt_oe0 got=%b exp=00", {bus.int_wr_q, bus.busy});
        end
        bus.req_halt = 1'b0;
        bus.clk_oe = 1'b1;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(bus.rsp_rd_dn || bus.rsp_wr_dn || bus.rsp_err);
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL halt_no_rsp pulses=%0d exp=0", pulses);
        end
    endtask
    task automatic test_rst_mid();
        int pulses = 0;
        start(1'b1, 1'b0, 32'd10, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.req_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.int_rd_q, bus.busy, bus.rsp_rd_dn} !== 3'b000 || bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got=%b rdata=%h exp=000/00000000", {bus.int_rd_q, bus.busy, bus.rsp_rd_dn}, bus.rsp_rdata);
        end
        repeat (4) begin
            @(negedge clk);
            pulses += int'(bus.rsp_rd_dn || bus.rsp_wr_dn || bus.rsp_err);
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL rst_mid_no_rsp pulses=%0d exp=0", pulses);
        end
    endtask
    task automatic test_clk_oe();
        int lat = 0, pcnt = 0;
        logic [33:0] snap = '0;
        auto_int = 1'b1;
        bus.int_rdata = 32'h0F0F;
        start(1'b1, 1'b0, 32'd10, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) snap = {bus.int_rd_q, bus.busy, bus.int_addr};
            if (i == 2) begin
                checks++;
                if ({bus.int_rd_q, bus.busy, bus.int_addr} !== snap || snap !== {2'b11, 32'd10}) begin
                    failures++;
                    $display("FAIL clk_oe_hold got=%h first=%h exp=3_0000000a", {bus.int_rd_q, bus.busy, bus.int_addr}, snap);
                end
            end
            if (bus.rsp_rd_dn) begin
                pcnt++;
                if (lat == 0) lat = i;
                bus.req_rd = 1'b0;
            end
            bus.clk_oe = ~bus.clk_oe;
        end
        bus.clk_oe = 1'b1;
        checks++;
        if (lat !== 5 || pcnt !== 2) begin
            failures++;
            $display("FAIL clk_oe_latency lat=%0d pulse_clks=%0d exp=5/2", lat, pcnt);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0F0F || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL clk_oe_result data=%h busy=%b exp=00000f0f/0", bus.rsp_rdata, bus.busy);
        end
        auto_int = 1'b0;
    endtask
    initial begin
        bus.clk_oe    = 1'b1;
        bus.req_rd    = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_halt  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.int_rdata = '0;
        bus.ext_rdata = '0;
        test_reset();
        test_int_read();
        test_ext_write();
        test_boundary();
        test_timeout();
        test_stray();
        test_halt();
        test_rst_mid();
        test_clk_oe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
